fsm_read_responder: RTL and testbench

Target-side responder for the rd/ws/ds read handshake driven by the read-controller FSM (IDLE→READ→DLY→DONE). It watches `rd`, answers each DLY phase with a wait-state flag `ws` from a per-transaction wait count, and fetches one word per transaction from an asynchronous-read memory at an auto-incrementing address. The captured word is presented with `rvalid` in the same cycle the initiator asserts `ds`. It sits on the peripheral side of the read interface, opposite the read controller.

---
 rtl/fsm_read_responder.sv | 100 ++++++++++
 tb/tb_fsm_read_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fsm_read_responder.sv
// Target-side responder for the rd/ws/ds read handshake: tracks the initiator's
// READ/DLY loop, answers with wait states and fetches one word per transaction.
module fsm_read_responder #(
    parameter int DW  = 8,
    parameter int AW  = 4,
    parameter int WCW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rd,
    input  logic [WCW-1:0] wait_cfg,
    input  logic [DW-1:0]  mem_rdata,
    output logic           ws,
    output logic [AW-1:0]  addr,
    output logic [DW-1:0]  rdata,
    output logic           rvalid,
    output logic           err
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DLY  = 2'd1,
        R_READ = 2'd2,
        R_DONE = 2'd3
    } state_t;

    state_t         state, state_nx;
    logic [WCW-1:0] wcnt, wcnt_nx;
    logic [AW-1:0]  addr_nx;
    logic [DW-1:0]  rdata_nx;
    logic           err_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= R_IDLE;
            wcnt  <= '0;
            addr  <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            addr  <= addr_nx;
            rdata <= rdata_nx;
            err   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        addr_nx  = addr;
        rdata_nx = rdata;
        err_nx   = 1'b0;
        case (state)
            R_IDLE: begin
                if (rd) begin
                    wcnt_nx  = wait_cfg;
                    state_nx = R_DLY;
                end
            end
            R_DLY: begin
                // A dropped strobe wins over the capture, so an abort never moves addr/rdata.
                if (!rd) begin
                    err_nx   = 1'b1;
                    state_nx = R_IDLE;
                end else if (wcnt != '0) begin
                    wcnt_nx  = wcnt - 1'b1;
                    state_nx = R_READ;
                end else begin
                    rdata_nx = mem_rdata;
                    addr_nx  = addr + 1'b1;
                    state_nx = R_DONE;
                end
            end
            R_READ: begin
                if (rd) begin
                    state_nx = R_DLY;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = R_IDLE;
                end
            end
            R_DONE: begin
                err_nx   = rd;
                state_nx = R_IDLE;
            end
            default: begin
                state_nx = R_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; no path from rd or wait_cfg.
    always_comb begin
        ws     = (state == R_DLY) && (wcnt != '0);
        rvalid = (state == R_DONE);
    end

endmodule

// File: tb/tb_fsm_read_responder.sv
// Self-checking bench for fsm_read_responder: drives the initiator handshake and
// checks every cycle against a per-transaction timeline model.
module tb_fsm_read_responder;

    logic       clk;
    logic       rst_n;
    logic       rd;
    logic [3:0] wait_cfg;
    logic [7:0] mem_rdata;
    logic       ws;
    logic [3:0] addr;
    logic [7:0] rdata;
    logic       rvalid;
    logic       err;

    logic [7:0] mem [16];
    logic [3:0] exp_addr;
    logic [7:0] exp_rdata;
    int         n_checks;
    int         n_fail;

    fsm_read_responder #(.DW(8), .AW(4), .WCW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (rd),
        .wait_cfg  (wait_cfg),
        .mem_rdata (mem_rdata),
        .ws        (ws),
        .addr      (addr),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb mem_rdata = mem[addr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_ws, input logic e_rv, input logic e_err);
        chk({tag, ":ws"},     32'(ws),     32'(e_ws));
        chk({tag, ":rvalid"}, 32'(rvalid), 32'(e_rv));
        chk({tag, ":err"},    32'(err),    32'(e_err));
        chk({tag, ":addr"},   32'(addr),   32'(exp_addr));
        chk({tag, ":rdata"},  32'(rdata),  32'(exp_rdata));
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge.
    task automatic step(input logic r, input logic [3:0] wc);
        @(posedge clk);
        #1;
        rd       = r;
        wait_cfg = wc;
        @(negedge clk);
    endtask

    // One initiator transaction with N wait states. abort_at=k drops rd in cycle k;
    // hold_done keeps rd high in the DONE cycle; mid_cfg<0 randomizes wait_cfg after c0.
    task automatic txn(input int n, input int abort_at, input bit hold_done, input int mid_cfg);
        int         last;
        logic [3:0] wc;
        last = 2 * n + 1;
        wc   = 4'(n);
        step(1'b1, 4'(n));
        check_outs("c0", 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= last; k++) begin
            wc = (mid_cfg < 0) ? 4'($urandom_range(0, 15)) : 4'(mid_cfg);
            step((abort_at == k) ? 1'b0 : 1'b1, wc);
            check_outs($sformatf("n%0d_c%0d", n, k), (k % 2 == 1) && (k < last), 1'b0, 1'b0);
            if (abort_at == k) begin
                step(1'b0, wc);
                check_outs("abort_err", 1'b0, 1'b0, 1'b1);
                step(1'b0, wc);
                check_outs("abort_after", 1'b0, 1'b0, 1'b0);
                return;
            end
        end
        exp_rdata = mem[exp_addr];
        exp_addr  = exp_addr + 4'd1;
        step(hold_done, wc);
        check_outs($sformatf("n%0d_done", n), 1'b0, 1'b1, 1'b0);
        step(1'b0, wc);
        check_outs("post_done", 1'b0, 1'b0, hold_done);
        if (hold_done) begin
            step(1'b0, wc);
            check_outs("post_hold", 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int n;
        int r;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        rd        = 1'b0;
        wait_cfg  = 4'd0;
        exp_addr  = 4'd0;
        exp_rdata = 8'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        rst_n = 1'b1;
        step(1'b0, 4'd0);
        check_outs("idle", 1'b0, 1'b0, 1'b0);

        mem[0] = 8'hA5;
        txn(0, 0, 1'b0, 0);
        mem[1] = 8'h3C;
        txn(3, 0, 1'b0, 3);

        // Asynchronous reset in c3 of a two-wait transaction.
        step(1'b1, 4'd2);
        check_outs("rst_c0", 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd2);
        check_outs("rst_c1", 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd2);
        check_outs("rst_c2", 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd2);
        check_outs("rst_c3", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_addr  = 4'd0;
        exp_rdata = 8'd0;
        check_outs("rst_async", 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0);
        check_outs("rst_hold", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 4'd0);
        check_outs("rst_rel", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);
        for (int i = 0; i < 16; i++) txn(0, 0, 1'b0, 0);
        chk("wrap_addr", 32'(addr), 32'd0);

        txn(2, 2, 1'b0, 2);
        txn(1, 0, 1'b0, 1);
        txn(0, 0, 1'b1, 0);
        txn(0, 0, 1'b0, 0);
        txn(2, 0, 1'b0, 0);

        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 4);
            r = $urandom_range(0, 9);
            if (r < 2)
                txn(n, $urandom_range(1, 2 * n + 1), 1'b0, -1);
            else
                txn(n, 0, (r == 2), -1);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                step(1'b0, 4'($urandom_range(0, 15)));
                check_outs("gap", 1'b0, 1'b0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
